char_tracker: RTL and testbench
===============================

Name: char_tracker

Overview:
- Consumer end of the falling-character generator.
- Accepts spawn offers (ch, speed, column) into a fixed pool of slots and advances every live character downward on each frame tick.
- Retires a character when a matching key press arrives (hit) or when it crosses the bottom limit (miss).
- Exposes a random-access read port for the VGA renderer, plus hit and miss counters for the score display.

Parameters:
- SLOTS, 8, number of character slots (power of two, 2..16).
- X_LIMIT, 9'd464, row at or beyond which a falling character counts as missed.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spawn_req  in  1  generator offers a new character this cycle.
- spawn_ch  in  8  ASCII code, 'A'..'Z' (65..90).
- spawn_speed  in  3  rows advanced per tick; 0 is treated as 1.
- spawn_y  in  10  horizontal pixel column.
- spawn_ack  out  1  registered; high one cycle after an accepted spawn.
- tick  in  1  one-cycle frame pulse that triggers movement.
- key_valid  in  1  one-cycle pulse, key_code valid.
- key_code  in  8  ASCII code of the pressed key.
- hit  out  1  registered one-cycle pulse: a slot was retired by a key.
- miss  out  1  registered one-cycle pulse: at least one slot fell out this tick.
- hit_cnt  out  CNT_W  total hits, saturating.
- miss_cnt  out  CNT_W  total misses, saturating.
- rd_idx  in  log2(SLOTS)  slot select for the renderer.
- rd_valid  out  1  combinational read of the selected slot: slot occupied.
- rd_ch  out  8  combinational read: character code.
- rd_x  out  9  combinational read: vertical row.
- rd_y  out  10  combinational read: horizontal column.
- full  out  1  combinational; all slots occupied.

Behaviour:
- Reset (async, rst=1):
  - All slot valid bits cleared; slot fields cleared to 0.
  - spawn_ack, hit and miss low; hit_cnt and miss_cnt reset to 0.
- Per-slot state: valid, ch[7:0], spd[2:0] (stored as max(spawn_speed,1)), x[9:0] internal, y[9:0].
- All decisions in a cycle use the pre-edge slot state. Updates commit at the clock edge.
- Key match:
  - When key_valid is high, candidates are valid slots with ch==key_code.
  - Choose the candidate with the largest x; on a tie, the lowest index.
  - Clear the chosen slot. Next cycle hit=1 and hit_cnt increments (saturates at all-ones).
  - No candidate: no effect, no pulse.
- Tick:
  - For every valid slot not retired by a key in the same cycle, compute nx = x + spd using a 10-bit sum, so there is no wrap.
  - If nx >= X_LIMIT: clear the slot and count it.
  - Otherwise: x <= nx.
  - If k>=1 slots fall in one tick: miss=1 for one cycle and miss_cnt += k (saturating).
- Spawn:
  - Accepted iff spawn_req and at least one slot is free in the pre-edge state.
  - A slot freed in the same cycle is not reusable until the next cycle.
  - Writes the lowest-index free slot with x=0. spawn_ack=1 the next cycle.
  - The new slot is not moved by a tick in the same cycle.
  - When full, the request is ignored and there is no ack; the generator holds or drops the offer.
- Simultaneous key + tick on the same slot: the hit wins, and the slot is not counted as a miss.
- rd_x outputs x[8:0]. Internal x never exceeds X_LIMIT+7, so it fits in 10 bits.
- Read port: pure mux of slot registers. Reflects the state after the last edge.
- Reset asserted mid-operation: all state cleared immediately; in-flight pulses dropped.

Decomposition:
- Shared package holds:
  - CH_A=8'd65 and CH_Z=8'd90.
  - Slot field widths: CH_W=8, SPD_W=3, X_W=9, Y_W=10.
  - Default X_LIMIT.
  - A slot record typedef (valid, ch, spd, x, y).
- One natural sub-module: char_match_sel, a combinational arbiter.
  - Inputs: valid/ch/x vectors and key_code.
  - Outputs: found and idx, using the largest-x / lowest-index rule.
- Free-slot priority encoding stays inline.

Test Plan:
- Reset, then spawn_req with ch=65, speed=3, y=120 → spawn_ack next cycle; rd_idx=0 reads valid=1, ch=65, x=0, y=120.
- Same slot, 5 ticks → rd_x=15. Spawn with speed=0, 4 ticks → x=4.
- Slot 0 ch=66 at x=40 and slot 2 ch=66 at x=90; key_valid with key_code=66 → slot 2 cleared, slot 0 intact, hit pulse, hit_cnt=1. Key 67 → no change.
- Two slots with speed=7 near the limit (x=460 and x=462, X_LIMIT=464), one tick → both cleared, one miss pulse, miss_cnt=2. A slot at x=450 with speed 7 → x=457, kept.
- Fill all 8 slots → full=1. A ninth spawn_req → no ack. A key hit plus spawn_req in the same cycle → hit only; spawn accepted on the next cycle into the freed index.
- Key hit and tick on a slot about to fall → hit=1, miss stays 0. Assert rst mid-stream → all rd_valid=0 and counters 0 with no clock edge.

Source files
------------

// File: rtl/char_tracker_pkg.sv
// Shared definitions for the falling-character tracker: field widths,
// character range, default bottom limit and the slot record.
package char_tracker_pkg;

    localparam logic [7:0] CH_A = 8'd65;
    localparam logic [7:0] CH_Z = 8'd90;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned SPD_W = 3;
    localparam int unsigned X_W   = 9;
    localparam int unsigned XI_W  = 10;
    localparam int unsigned Y_W   = 10;

    localparam logic [X_W-1:0] X_LIMIT_DEF = 9'd464;

    // x carries one extra bit so x + spd cannot wrap before the limit test
    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  ch;
        logic [SPD_W-1:0] spd;
        logic [XI_W-1:0]  x;
        logic [Y_W-1:0]   y;
    } slot_t;

    function automatic logic [SPD_W-1:0] norm_speed(input logic [SPD_W-1:0] s);
        return (s == '0) ? SPD_W'(1) : s;
    endfunction

endpackage

// File: rtl/char_match_sel.sv
// Combinational key arbiter: among valid slots holding key_code, picks the
// one with the largest x, lowest index on a tie.
module char_match_sel
    import char_tracker_pkg::*;
#(
    parameter int unsigned SLOTS = 8,
    parameter int unsigned IDX_W = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0]      valid,
    input  logic [SLOTS*CH_W-1:0] ch,
    input  logic [SLOTS*XI_W-1:0] x,
    input  logic [CH_W-1:0]       key_code,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    logic [XI_W-1:0] best_x;
    logic            any;

    // strict '>' keeps the earliest index when x values tie
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        best_x = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (valid[i] && (ch[i*CH_W +: CH_W] == key_code) &&
                (!any || (x[i*XI_W +: XI_W] > best_x))) begin
                any    = 1'b1;
                idx    = IDX_W'(i);
                best_x = x[i*XI_W +: XI_W];
            end
        end
        found = any;
    end

endmodule

// File: rtl/char_tracker.sv
// Slot pool for falling characters: spawn, per-tick movement, key hits,
// bottom misses, saturating score counters and a renderer read port.
module char_tracker
    import char_tracker_pkg::*;
#(
    parameter int unsigned      SLOTS   = 8,
    parameter logic [X_W-1:0]   X_LIMIT = X_LIMIT_DEF,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spawn_req,
    input  logic [7:0]               spawn_ch,
    input  logic [2:0]               spawn_speed,
    input  logic [9:0]               spawn_y,
    output logic                     spawn_ack,
    input  logic                     tick,
    input  logic                     key_valid,
    input  logic [7:0]               key_code,
    output logic                     hit,
    output logic                     miss,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt,
    input  logic [$clog2(SLOTS)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [7:0]               rd_ch,
    output logic [8:0]               rd_x,
    output logic [9:0]               rd_y,
    output logic                     full
);

    localparam int unsigned IDX_W = $clog2(SLOTS);
    localparam int unsigned K_W   = $clog2(SLOTS + 1);

    slot_t slots   [SLOTS];
    slot_t slots_n [SLOTS];

    logic [SLOTS-1:0]      valid_vec;
    logic [SLOTS*CH_W-1:0] ch_vec;
    logic [SLOTS*XI_W-1:0] x_vec;

    logic                  match_found;
    logic [IDX_W-1:0]      match_idx;
    logic                  hit_go;

    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  spawn_go;

    logic [XI_W-1:0]       nx;
    logic [K_W-1:0]        miss_k;
    logic [CNT_W:0]        miss_sum;

    always_comb begin
        valid_vec = '0;
        ch_vec    = '0;
        x_vec     = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            valid_vec[i]             = slots[i].valid;
            ch_vec[i*CH_W +: CH_W]   = slots[i].ch;
            x_vec[i*XI_W +: XI_W]    = slots[i].x;
        end
    end

    char_match_sel #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_match (
        .valid    (valid_vec),
        .ch       (ch_vec),
        .x        (x_vec),
        .key_code (key_code),
        .found    (match_found),
        .idx      (match_idx)
    );

    assign hit_go = key_valid && match_found;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!slots[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign spawn_go = spawn_req && free_found;

    // Every decision reads the pre-edge slots; a freed slot only looks free next cycle.
    always_comb begin
        nx     = '0;
        miss_k = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            slots_n[i] = slots[i];
        end

        if (hit_go) begin
            slots_n[match_idx] = '0;
        end

        if (tick) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (slots[i].valid && !(hit_go && (match_idx == IDX_W'(i)))) begin
                    nx = slots[i].x + XI_W'(slots[i].spd);
                    if (nx >= XI_W'(X_LIMIT)) begin
                        slots_n[i] = '0;
                        miss_k     = miss_k + K_W'(1);
                    end else begin
                        slots_n[i].x = nx;
                    end
                end
            end
        end

        if (spawn_go) begin
            slots_n[free_idx].valid = 1'b1;
            slots_n[free_idx].ch    = spawn_ch;
            slots_n[free_idx].spd   = norm_speed(spawn_speed);
            slots_n[free_idx].x     = '0;
            slots_n[free_idx].y     = spawn_y;
        end
    end

    assign miss_sum = {1'b0, miss_cnt} + (CNT_W+1)'(miss_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
            spawn_ack <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slots[i] <= slots_n[i];
            end
            spawn_ack <= spawn_go;
            hit       <= hit_go;
            miss      <= (miss_k != '0);
            if (hit_go && !(&hit_cnt)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_k != '0) begin
                miss_cnt <= miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
            end
        end
    end

    assign rd_valid = slots[rd_idx].valid;
    assign rd_ch    = slots[rd_idx].ch;
    assign rd_x     = slots[rd_idx].x[X_W-1:0];
    assign rd_y     = slots[rd_idx].y;
    assign full     = &valid_vec;

endmodule

// File: tb/tb_char_tracker.sv
// Bench for char_tracker: directed stimulus, a behavioural slot-pool model
// checked every cycle, plus literal expectations that pin the model.
module tb_char_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spawn_req = 1'b0;
    logic [7:0] spawn_ch = '0;
    logic [2:0] spawn_speed = '0;
    logic [9:0] spawn_y = '0;
    logic       spawn_ack;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = '0;
    logic       hit, miss;
    logic [15:0] hit_cnt, miss_cnt;
    logic [2:0] rd_idx = '0;
    logic       rd_valid;
    logic [7:0] rd_ch;
    logic [8:0] rd_x;
    logic [9:0] rd_y;
    logic       full;

    char_tracker #(
        .SLOTS   (8),
        .X_LIMIT (9'd464),
        .CNT_W   (16)
    ) dut (
        .clk(clk), .rst(rst),
        .spawn_req(spawn_req), .spawn_ch(spawn_ch), .spawn_speed(spawn_speed),
        .spawn_y(spawn_y), .spawn_ack(spawn_ack),
        .tick(tick), .key_valid(key_valid), .key_code(key_code),
        .hit(hit), .miss(miss), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x),
        .rd_y(rd_y), .full(full)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the slot pool
    int m_valid [8];
    int m_ch    [8];
    int m_spd   [8];
    int m_x     [8];
    int m_y     [8];
    int e_ack, e_hit, e_miss, e_hcnt, e_mcnt;

    always @(posedge clk or posedge rst) begin
        int pv [8];
        int px [8];
        int best, k, fr;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 0; m_ch[i] = 0; m_spd[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            e_ack = 0; e_hit = 0; e_miss = 0; e_hcnt = 0; e_mcnt = 0;
        end else begin
            pv = m_valid;
            px = m_x;
            e_ack = 0; e_hit = 0; e_miss = 0;
            best = -1;
            if (key_valid) begin
                for (int i = 0; i < 8; i++)
                    if (pv[i] != 0 && m_ch[i] == int'(key_code) && (best < 0 || px[i] > px[best]))
                        best = i;
            end
            if (best >= 0) begin
                m_valid[best] = 0;
                e_hit = 1;
                if (e_hcnt < 65535) e_hcnt++;
            end
            k = 0;
            if (tick) begin
                for (int i = 0; i < 8; i++) begin
                    if (pv[i] != 0 && i != best) begin
                        if (px[i] + m_spd[i] >= 464) begin
                            m_valid[i] = 0;
                            k++;
                        end else begin
                            m_x[i] = px[i] + m_spd[i];
                        end
                    end
                end
            end
            if (k > 0) begin
                e_miss = 1;
                e_mcnt = (e_mcnt + k > 65535) ? 65535 : e_mcnt + k;
            end
            fr = -1;
            for (int i = 7; i >= 0; i--) if (pv[i] == 0) fr = i;
            if (spawn_req && fr >= 0) begin
                m_valid[fr] = 1;
                m_ch[fr]    = int'(spawn_ch);
                m_spd[fr]   = (spawn_speed == 3'd0) ? 1 : int'(spawn_speed);
                m_x[fr]     = 0;
                m_y[fr]     = int'(spawn_y);
                e_ack = 1;
            end
        end
    end

    // Compare process: outputs and every slot via the read port
    always @(negedge clk) begin
        int nf;
        if (run) begin
            nf = 1;
            for (int i = 0; i < 8; i++) if (m_valid[i] == 0) nf = 0;
            chk("spawn_ack", 32'(spawn_ack), 32'(e_ack));
            chk("hit", 32'(hit), 32'(e_hit));
            chk("miss", 32'(miss), 32'(e_miss));
            chk("hit_cnt", 32'(hit_cnt), 32'(e_hcnt));
            chk("miss_cnt", 32'(miss_cnt), 32'(e_mcnt));
            chk("full", 32'(full), 32'(nf));
            for (int i = 0; i < 8; i++) begin
                rd_idx = 3'(i);
                #1;
                chk("rd_valid", 32'(rd_valid), 32'(m_valid[i]));
                if (m_valid[i] != 0) begin
                    chk("rd_ch", 32'(rd_ch), 32'(m_ch[i]));
                    chk("rd_x", 32'(rd_x), 32'(m_x[i]));
                    chk("rd_y", 32'(rd_y), 32'(m_y[i]));
                end
            end
        end
    end

    task automatic step(input logic sr, input logic [7:0] sc, input logic [2:0] ss,
                        input logic [9:0] sy, input logic tk, input logic kv,
                        input logic [7:0] kc);
        spawn_req = sr; spawn_ch = sc; spawn_speed = ss; spawn_y = sy;
        tick = tk; key_valid = kv; key_code = kc;
        @(posedge clk);
        #2;
        spawn_req = 1'b0; tick = 1'b0; key_valid = 1'b0;
    endtask

    task automatic spawn(input logic [7:0] sc, input logic [2:0] ss, input logic [9:0] sy);
        step(1'b1, sc, ss, sy, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 3'd0, 10'd0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        #25 rst = 1'b0;
        run = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("reset_full", 32'(full), 32'd0);

        // basic spawn and motion
        spawn(8'd65, 3'd3, 10'd120);
        chk("first_ack", 32'(spawn_ack), 32'd1);
        chk("m_slot0_valid", 32'(m_valid[0]), 32'd1);
        chk("m_slot0_y", 32'(m_y[0]), 32'd120);
        ticks(5);
        chk("m_slot0_x_15", 32'(m_x[0]), 32'd15);
        spawn(8'd68, 3'd0, 10'd300);
        ticks(4);
        chk("m_slot1_x_4", 32'(m_x[1]), 32'd4);
        chk("m_slot0_x_27", 32'(m_x[0]), 32'd27);

        // key arbitration: largest x wins
        do_reset();
        spawn(8'd70, 3'd1, 10'd10);
        spawn(8'd71, 3'd1, 10'd20);
        spawn(8'd66, 3'd3, 10'd30);
        ticks(20);
        step(1'b0, 8'd0, 3'd0, 10'd0, 1'b0, 1'b1, 8'd70);
        chk("hit_pulse_70", 32'(hit), 32'd1);
        spawn(8'd66, 3'd4, 10'd40);
        ticks(10);
        chk("m_slot0_x_40", 32'(m_x[0]), 32'd40);
        chk("m_slot2_x_90", 32'(m_x[2]), 32'd90);
        step(1'b0, 8'd0, 3'd0, 10'd0, 1'b0, 1'b1, 8'd66);
        chk("hit_pulse_66", 32'(hit), 32'd1);
        chk("hit_cnt_2", 32'(hit_cnt), 32'd2);
        chk("m_slot2_gone", 32'(m_valid[2]), 32'd0);
        chk("m_slot0_kept", 32'(m_valid[0]), 32'd1);
        step(1'b0, 8'd0, 3'd0, 10'd0, 1'b0, 1'b1, 8'd67);
        chk("no_hit_67", 32'(hit), 32'd0);
        chk("hit_cnt_still_2", 32'(hit_cnt), 32'd2);

        // bottom limit: 460+4 == limit and 462+7 both fall in one tick
        do_reset();
        spawn(8'd65, 3'd4, 10'd1);
        ticks(49);
        spawn(8'd66, 3'd7, 10'd2);
        ticks(66);
        chk("m_x_460", 32'(m_x[0]), 32'd460);
        chk("m_x_462", 32'(m_x[1]), 32'd462);
        chk("no_miss_yet", 32'(miss_cnt), 32'd0);
        ticks(1);
        chk("miss_pulse", 32'(miss), 32'd1);
        chk("miss_cnt_2", 32'(miss_cnt), 32'd2);

        // pool full, hit frees a slot only for the following cycle
        do_reset();
        for (int i = 0; i < 8; i++) spawn(8'(65 + i), 3'd1, 10'(i * 16));
        chk("full_8", 32'(full), 32'd1);
        spawn(8'd90, 3'd1, 10'd500);
        chk("ninth_no_ack", 32'(spawn_ack), 32'd0);
        step(1'b1, 8'd90, 3'd2, 10'd500, 1'b0, 1'b1, 8'd67);
        chk("hit_with_spawn", 32'(hit), 32'd1);
        chk("spawn_blocked", 32'(spawn_ack), 32'd0);
        spawn(8'd90, 3'd2, 10'd500);
        chk("spawn_after_free", 32'(spawn_ack), 32'd1);
        chk("m_slot2_ch_90", 32'(m_ch[2]), 32'd90);

        // hit beats miss on the same slot
        do_reset();
        spawn(8'd80, 3'd7, 10'd77);
        ticks(66);
        step(1'b0, 8'd0, 3'd0, 10'd0, 1'b1, 1'b1, 8'd80);
        chk("hit_over_miss_hit", 32'(hit), 32'd1);
        chk("hit_over_miss_miss", 32'(miss), 32'd0);
        chk("hit_over_miss_cnt", 32'(miss_cnt), 32'd0);

        // asynchronous reset mid-stream
        spawn(8'd81, 3'd2, 10'd5);
        spawn(8'd82, 3'd2, 10'd6);
        ticks(3);
        #1 rst = 1'b1;
        #3;
        chk("async_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("async_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("async_full", 32'(full), 32'd0);
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        #2 rst = 1'b0;
        ticks(2);

        @(posedge clk);
        #2;
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
